// File: rtl/seg7_pkg.sv
// Shared 7-segment tables and dwell-state encoding for the display encoder/decoder pair.
// Segment order is {a,b,c,d,e,f,g}, active-high.
package seg7_pkg;

  localparam logic [6:0] SEG_0    = 7'b1111110;
  localparam logic [6:0] SEG_1    = 7'b0110000;
  localparam logic [6:0] SEG_2    = 7'b1101101;
  localparam logic [6:0] SEG_3    = 7'b1111001;
  localparam logic [6:0] SEG_4    = 7'b0110011;
  localparam logic [6:0] SEG_5    = 7'b1011011;
  localparam logic [6:0] SEG_6    = 7'b1011111;
  localparam logic [6:0] SEG_7    = 7'b1110000;
  localparam logic [6:0] SEG_8    = 7'b1111111;
  localparam logic [6:0] SEG_9    = 7'b1111011;
  localparam logic [6:0] SEG_DASH = 7'b0000001;

  localparam logic [3:0] CODE_DASH = 4'hF;
  localparam logic [3:0] CODE_BAD  = 4'hE;

  typedef enum logic [1:0] {
    ST_BLANK  = 2'd0,
    ST_SETTLE = 2'd1,
    ST_LOCKED = 2'd2
  } dwell_e;

endpackage

// File: rtl/seg7_enc.sv
// Combinational reverse lookup: segment pattern -> {err, code}.
// Anything outside the digit/dash table, including blank, decodes to CODE_BAD with err set.
module seg7_enc
  import seg7_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_code,
  output logic       o_err
);

  always_comb begin
    o_code = CODE_BAD;
    o_err  = 1'b0;
    case (i_seg)
      SEG_0:    o_code = 4'd0;
      SEG_1:    o_code = 4'd1;
      SEG_2:    o_code = 4'd2;
      SEG_3:    o_code = 4'd3;
      SEG_4:    o_code = 4'd4;
      SEG_5:    o_code = 4'd5;
      SEG_6:    o_code = 4'd6;
      SEG_7:    o_code = 4'd7;
      SEG_8:    o_code = 4'd8;
      SEG_9:    o_code = 4'd9;
      SEG_DASH: o_code = CODE_DASH;
      default: begin
        o_code = CODE_BAD;
        o_err  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg_scan_capture.sv
// Samples a one-hot scanned 7-segment drive, captures each digit after STABLE identical
// samples, and hands out one frame per full scan on a valid/ready output buffer.
module seg_scan_capture
  import seg7_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int STABLE = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          seg_in,
  input  logic [DIGITS-1:0]   dig_sel,
  output logic [4*DIGITS-1:0] frame_data,
  output logic                frame_err,
  output logic                frame_valid,
  input  logic                frame_ready,
  output logic                overrun
);

  localparam logic [3:0]        STB     = 4'(STABLE);
  localparam logic [DIGITS-1:0] SEL_ONE = DIGITS'(1);

  logic [DIGITS-1:0]   r_smp_sel;
  logic [6:0]          r_smp_seg;
  logic [DIGITS-1:0]   r_prv_sel;
  logic [6:0]          r_prv_seg;
  dwell_e              r_state;
  logic [3:0]          r_cnt;
  logic [4*DIGITS-1:0] r_slot;
  logic [DIGITS-1:0]   r_slot_err;
  logic [DIGITS-1:0]   r_mask;
  logic [4*DIGITS-1:0] r_data;
  logic                r_err;
  logic                r_vld;
  logic                r_ovr;

  logic [3:0]          w_code;
  logic                w_err;
  logic                w_same;
  logic                w_onehot;
  logic [3:0]          w_cnt_inc;
  logic                w_capture;
  logic                w_full;

  seg7_enc u_enc (
    .i_seg  (r_smp_seg),
    .o_code (w_code),
    .o_err  (w_err)
  );

  assign w_same    = ({r_smp_sel, r_smp_seg} == {r_prv_sel, r_prv_seg});
  assign w_onehot  = (r_smp_sel != '0) && ((r_smp_sel & (r_smp_sel - SEL_ONE)) == '0);
  assign w_cnt_inc = r_cnt + 4'd1;
  assign w_full    = &r_mask;

  // A changed sample restarts the dwell; only STABLE==1 can capture on that first sample.
  always_comb begin
    w_capture = 1'b0;
    if (r_state == ST_BLANK || !w_same) begin
      w_capture = w_onehot && (STB == 4'd1);
    end else if (r_state == ST_SETTLE) begin
      w_capture = (w_cnt_inc == STB);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_smp_sel <= '0;
      r_smp_seg <= '0;
      r_prv_sel <= '0;
      r_prv_seg <= '0;
    end else begin
      r_smp_sel <= dig_sel;
      r_smp_seg <= seg_in;
      r_prv_sel <= r_smp_sel;
      r_prv_seg <= r_smp_seg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_BLANK;
      r_cnt   <= 4'd0;
    end else if (r_state != ST_BLANK && w_same) begin
      if (r_state == ST_SETTLE) begin
        r_cnt <= w_cnt_inc;
        if (w_cnt_inc == STB) begin
          r_state <= ST_LOCKED;
        end
      end
    end else if (w_onehot) begin
      r_state <= (STB == 4'd1) ? ST_LOCKED : ST_SETTLE;
      r_cnt   <= 4'd1;
    end else begin
      r_state <= ST_BLANK;
      r_cnt   <= 4'd0;
    end
  end

  // The one-hot select doubles as the slot write strobe and the mask bit to set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot     <= '0;
      r_slot_err <= '0;
      r_mask     <= '0;
    end else begin
      r_mask <= (w_full ? '0 : r_mask) | (w_capture ? r_smp_sel : '0);
      for (int i = 0; i < DIGITS; i++) begin
        if (w_capture && r_smp_sel[i]) begin
          r_slot[4*i +: 4] <= w_code;
          r_slot_err[i]    <= w_err;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
      r_err  <= 1'b0;
      r_vld  <= 1'b0;
      r_ovr  <= 1'b0;
    end else begin
      r_ovr <= 1'b0;
      if (w_full) begin
        if (!r_vld || frame_ready) begin
          r_data <= r_slot;
          r_err  <= |r_slot_err;
          r_vld  <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (r_vld && frame_ready) begin
        r_vld <= 1'b0;
      end
    end
  end

  assign frame_data  = r_data;
  assign frame_err   = r_err;
  assign frame_valid = r_vld;
  assign overrun     = r_ovr;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Bench for seg_scan_capture: pin-level run list plus a dwell/frame reference model,
// followed by a cycle-by-cycle output check and directed end-of-run checks.
module tb_seg_scan_capture;

  localparam int DIGITS = 4;
  localparam int STABLE = 3;
  localparam int N      = 4000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  seg_in = '0;
  logic [3:0]  dig_sel = '0;
  logic        frame_ready = 1'b0;
  logic [15:0] frame_data;
  logic        frame_err;
  logic        frame_valid;
  logic        overrun;

  always #5 clk = ~clk;

  seg_scan_capture #(.DIGITS(DIGITS), .STABLE(STABLE)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_in      (seg_in),
    .dig_sel     (dig_sel),
    .frame_data  (frame_data),
    .frame_err   (frame_err),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .overrun     (overrun)
  );

  logic [6:0] seg_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                               7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

  // Per-cycle stimulus and expected frame-load events (load happens at the edge ending cycle c).
  logic [3:0]  p_sel [N];
  logic [6:0]  p_seg [N];
  logic        p_rst [N];
  logic        p_rdy [N];
  logic        ev_v  [N];
  logic        ev_e  [N];
  logic [15:0] ev_d  [N];

  int          cur;
  logic [10:0] m_prev;
  int          m_len;
  logic [3:0]  m_cap;
  logic [3:0]  m_slot [4];
  logic [3:0]  m_errb;
  int          last_ev;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] ref_decode(input logic [6:0] s);
    for (int k = 0; k < 10; k++) begin
      if (s == seg_tab[k]) return {1'b0, 4'(k)};
    end
    if (s == 7'b0000001) return {1'b0, 4'hF};
    return {1'b1, 4'hE};
  endfunction

  // A digit is captured on the STABLE-th consecutive identical pin cycle of a one-hot select.
  task automatic step_model(input int c);
    logic [10:0] v;
    logic [4:0]  dec;
    logic [15:0] d;
    v = {p_sel[c], p_seg[c]};
    if (v == m_prev) m_len++;
    else m_len = 1;
    m_prev = v;
    if (m_len == STABLE && $countones(p_sel[c]) == 1) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (p_sel[c][i]) begin
          dec       = ref_decode(p_seg[c]);
          m_slot[i] = dec[3:0];
          m_errb[i] = dec[4];
          m_cap[i]  = 1'b1;
        end
      end
      if (m_cap == 4'hF) begin
        for (int i = 0; i < DIGITS; i++) d[4*i +: 4] = m_slot[i];
        ev_v[c+2] = 1'b1;
        ev_d[c+2] = d;
        ev_e[c+2] = |m_errb;
        m_cap     = '0;
        last_ev   = c + 2;
      end
    end
  endtask

  task automatic put(input logic [3:0] sel, input logic [6:0] seg, input int len, input logic r);
    for (int i = 0; i < len; i++) begin
      p_sel[cur] = sel;
      p_seg[cur] = seg;
      p_rst[cur] = 1'b0;
      p_rdy[cur] = r;
      step_model(cur);
      cur++;
    end
  endtask

  task automatic dig(input int i, input logic [6:0] seg, input int len, input logic r);
    put(4'(1 << i), seg, len, r);
  endtask

  task automatic scan(input int c0, input int c1, input int c2, input int c3, input logic r);
    dig(0, seg_tab[c0], 5, r);
    dig(1, seg_tab[c1], 5, r);
    dig(2, seg_tab[c2], 5, r);
    dig(3, seg_tab[c3], 5, r);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      p_sel[cur] = '0;
      p_seg[cur] = '0;
      p_rst[cur] = 1'b1;
      p_rdy[cur] = 1'b0;
      step_model(cur);
      ev_v[cur] = 1'b0;
      cur++;
    end
    m_cap = '0;
  endtask

  logic        exp_v, exp_e, exp_o, prev_v;
  logic [15:0] exp_d;
  logic [16:0] xq [$];
  int          rise_q [$];
  int          t3, bp_a, bp_b, nb_cycle, ovr_cnt;
  logic [3:0]  rs;
  logic [6:0]  rg;

  initial begin
    for (int i = 0; i < N; i++) begin
      ev_v[i] = 1'b0;
      ev_e[i] = 1'b0;
      ev_d[i] = '0;
    end
    cur = 0; m_prev = '0; m_len = 0; m_cap = '0; m_errb = '0; last_ev = 0;
    for (int i = 0; i < 4; i++) m_slot[i] = '0;

    // Clean scan 1,2,3,4
    do_reset(2);
    put(4'b0000, 7'b0, 3, 1'b1);
    dig(0, seg_tab[1], 5, 1'b1);
    dig(1, seg_tab[2], 5, 1'b1);
    dig(2, seg_tab[3], 5, 1'b1);
    t3 = cur;
    dig(3, seg_tab[4], 5, 1'b1);
    put(4'b0000, 7'b0, 8, 1'b1);

    // Glitch on digit 0: "8" briefly, then "1"
    put(4'b0001, 7'b1111111, 2, 1'b1);
    put(4'b0001, seg_tab[1], 4, 1'b1);
    dig(1, seg_tab[5], 5, 1'b1);
    dig(2, seg_tab[6], 5, 1'b1);
    dig(3, seg_tab[7], 5, 1'b1);
    put(4'b0000, 7'b0, 8, 1'b1);

    // Dash and bad pattern
    dig(0, seg_tab[0], 5, 1'b1);
    dig(1, seg_tab[9], 5, 1'b1);
    dig(2, 7'b0000001, 5, 1'b1);
    dig(3, 7'b1010101, 5, 1'b1);
    put(4'b0000, 7'b0, 8, 1'b1);

    // Backpressure over two scans
    bp_a = cur;
    scan(8, 7, 6, 5, 1'b0);
    scan(1, 1, 1, 1, 1'b0);
    put(4'b0000, 7'b0, 8, 1'b0);
    put(4'b0000, 7'b0, 8, 1'b1);
    bp_b = cur;

    // Blanking and multi-hot gaps
    dig(0, seg_tab[2], 4, 1'b1);
    put(4'b0000, 7'b0, 2, 1'b1);
    put(4'b0011, seg_tab[8], 3, 1'b1);
    dig(1, seg_tab[4], 4, 1'b1);
    put(4'b0011, seg_tab[8], 3, 1'b1);
    put(4'b0000, 7'b0, 2, 1'b1);
    dig(2, seg_tab[6], 4, 1'b1);
    put(4'b0000, 7'b0, 2, 1'b1);
    dig(3, seg_tab[8], 4, 1'b1);
    put(4'b0000, 7'b0, 8, 1'b1);

    // Transfer of a held frame on the same edge as the next frame loads
    scan(9, 0, 1, 2, 1'b0);
    put(4'b0000, 7'b0, 4, 1'b0);
    scan(4, 5, 6, 7, 1'b0);
    put(4'b0000, 7'b0, 8, 1'b0);
    p_rdy[last_ev] = 1'b1;
    nb_cycle = last_ev + 1;
    put(4'b0000, 7'b0, 3, 1'b1);

    // Pending frame, then reset in the middle of a scan
    scan(1, 2, 3, 4, 1'b0);
    put(4'b0000, 7'b0, 6, 1'b0);
    dig(0, seg_tab[5], 5, 1'b0);
    dig(1, seg_tab[5], 2, 1'b0);
    do_reset(2);
    put(4'b0000, 7'b0, 3, 1'b1);
    scan(3, 1, 4, 1, 1'b1);
    put(4'b0000, 7'b0, 8, 1'b1);

    // Random runs
    for (int n = 0; n < 300; n++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind < 7) rs = 4'(1 << $urandom_range(0, 3));
      else if (kind == 7) rs = 4'b0000;
      else begin
        rs = 4'($urandom_range(0, 15));
        if ($countones(rs) < 2) rs = 4'b1010;
      end
      if ($urandom_range(0, 3) != 0) rg = seg_tab[$urandom_range(0, 9)];
      else rg = 7'($urandom_range(0, 127));
      put(rs, rg, $urandom_range(1, 6), 1'($urandom_range(0, 1)));
    end
    put(4'b0000, 7'b0, 10, 1'b1);

    exp_v = 1'b0; exp_e = 1'b0; exp_o = 1'b0; exp_d = '0; prev_v = 1'b0; ovr_cnt = 0;
    @(posedge clk);
    for (int k = 0; k < cur; k++) begin
      #1;
      rst         = p_rst[k];
      dig_sel     = p_sel[k];
      seg_in      = p_seg[k];
      frame_ready = p_rdy[k];
      @(negedge clk);
      chk("frame_valid", 32'(frame_valid), 32'(exp_v));
      chk("frame_data",  32'(frame_data),  32'(exp_d));
      chk("frame_err",   32'(frame_err),   32'(exp_e));
      chk("overrun",     32'(overrun),     32'(exp_o));
      if (frame_valid && !prev_v) rise_q.push_back(k);
      prev_v = frame_valid;
      if (frame_valid && frame_ready && !rst) xq.push_back({frame_err, frame_data});
      if (overrun && k >= bp_a && k < bp_b) ovr_cnt++;
      if (k == nb_cycle) begin
        chk("nobubble_valid", 32'(frame_valid), 32'd1);
        chk("nobubble_data",  32'(frame_data),  32'h7654);
      end
      @(posedge clk);
      if (p_rst[k]) begin
        exp_v = 1'b0; exp_e = 1'b0; exp_o = 1'b0; exp_d = '0;
      end else begin
        exp_o = ev_v[k] && exp_v && !p_rdy[k];
        if (ev_v[k] && (!exp_v || p_rdy[k])) begin
          exp_v = 1'b1;
          exp_d = ev_d[k];
          exp_e = ev_e[k];
        end else if (exp_v && p_rdy[k]) begin
          exp_v = 1'b0;
        end
      end
    end

    chk("first_rise_cycle", 32'(rise_q.size() > 0 ? rise_q[0] : -1), 32'(t3 + STABLE + 2));
    chk("bp_overrun_pulses", 32'(ovr_cnt), 32'd1);
    chk("xfer_count_min", 32'(xq.size() >= 8), 32'd1);
    if (xq.size() >= 8) begin
      chk("xfer0_clean",    32'(xq[0]), 32'h04321);
      chk("xfer1_glitch",   32'(xq[1]), 32'h07651);
      chk("xfer2_dash_bad", 32'(xq[2]), 32'h1EF90);
      chk("xfer3_bp_held",  32'(xq[3]), 32'h05678);
      chk("xfer4_blanking", 32'(xq[4]), 32'h08642);
      chk("xfer5_sim_old",  32'(xq[5]), 32'h02109);
      chk("xfer6_sim_new",  32'(xq[6]), 32'h07654);
      chk("xfer7_post_rst", 32'(xq[7]), 32'h01413);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
